result_streamer: RTL and testbench
==================================

// Module: result_streamer
// PURPOSE
//  Downstream of the convolution controller. On the rising edge of the controller's done level,
//  snapshots the three 2x2 result sets (PE, SA2x2, SA3x3) and cross-checks them element by element.
//  Then emits a 14-byte frame over a valid/ready byte stream to the display/UART stage:
//  header, 12 result bytes, status byte. Also drives sticky match/mismatch flags for LEDs.
// PARAMETERS
//  DATA_W   8      width of each result element and of the stream byte
//  HEADER   8'hA5  first byte of every frame
//  N_BYTES  14     frame length (header + 12 results + status); fixed, not for override
// PORTS
//  clk          in   1        single clock, rising edge
//  rst_n        in   1        asynchronous, active-low reset
//  conv_done    in   1        controller done level; only its 0->1 edge triggers a frame
//  pe_c11..c22  in   4x8      PE results c11,c12,c21,c22
//  sa2_c11..c22 in   4x8      SA2x2 results
//  sa3_c11..c22 in   4x8      SA3x3 results
//  out_data     out  8        stream byte
//  out_valid    out  1        out_data is valid
//  out_ready    in   1        sink accepts when out_valid&&out_ready at clk edge
//  busy         out  1        high from capture until last byte accepted
//  frame_done   out  1        one-cycle pulse after status byte accepted
//  all_match    out  1        sticky: last frame had all 12 elements consistent
//  mismatch     out  4        sticky per-element mismatch mask {c22,c21,c12,c11}
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0, FSM=IDLE, done_q=0, byte index=0, snapshot regs 0.
//  Edge detect: done_q <= conv_done every cycle; trig = conv_done & ~done_q.
//  FSM: IDLE -> CAPTURE -> SEND -> FINISH -> IDLE.
//   IDLE: trig -> CAPTURE. trig while not IDLE is dropped (no queueing).
//   CAPTURE (1 cycle): latch 12 inputs; compute mask[i] = (pe!=sa2)|(pe!=sa3) per element.
//     Update mismatch<=mask, all_match<=(mask==0). busy=1 from this cycle.
//   SEND: out_valid=1, out_data = byte[idx]; idx 0..13:
//     0 HEADER; 1-4 PE c11,c12,c21,c22; 5-8 SA2 same order; 9-12 SA3 same order;
//     13 status = {all_match,3'b000,mismatch}.
//     On valid&&ready: idx++. Accepting idx 13 -> FINISH.
//     out_data/out_valid are registered; held stable while ready=0 (no retraction, no change).
//   FINISH (1 cycle): frame_done=1, busy=0, out_valid=0, idx=0 -> IDLE.
//  Latency: trig cycle N -> out_valid first high cycle N+2. With ready tied 1: one byte per cycle,
//   frame_done at N+16.
//  conv_done held high: one frame only. Must go low then high again to re-trigger.
//  Inputs may change after CAPTURE; the frame carries snapshot values only.
//  Sticky flags persist across frames until next CAPTURE or reset.
//  Reset mid-frame: stream aborts immediately; no partial-frame resume.
//   If conv_done is high when rst_n releases, done_q=0 gives a trig on the first clock.
//   This is intended.
//  No arithmetic beyond equality compare; all data unsigned DATA_W, passed unmodified.
// STRUCTURE
//  Shared package conv_pkg: DATA_W, HEADER, N_BYTES, FSM state encoding
//   (IDLE/CAPTURE/SEND/FINISH, 2-bit), status-byte bit positions.
//  Submodule: byte_stream_tx — the registered valid/ready output stage with byte index counter.
//   The top keeps edge detect, snapshot and compare.
// TESTING
//  1 Standard data (map 1..16, X-kernel), all three sets = {30,35,50,55}; ready=1
//    -> A5,1E,23,32,37 x3,80; all_match=1; frame_done at trig+16.
//  2 sa3_c21=51, rest as 1 -> byte 11=33, status=0x04, mismatch=4'b0100, all_match=0.
//  3 Backpressure: ready toggles 1,0,0,1... -> out_data/out_valid stable through stalls;
//    exactly 14 accepted bytes, correct order.
//  4 conv_done held high 50 cycles, plus second 0->1 edge mid-frame
//    -> single frame; second edge ignored; busy never re-asserts early.
//  5 rst_n low at byte 6 -> out_valid=0, busy=0, flags 0 same cycle.
//    A new edge afterwards yields a full fresh frame.
//  6 Inputs change the cycle after CAPTURE -> streamed bytes equal captured values.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants, FSM encoding and helpers for the result streamer.
package conv_pkg;

    localparam int DATA_W  = 8;
    localparam int N_ELEM  = 4;                  // c11, c12, c21, c22
    localparam int N_BYTES = 14;                 // header + 3*N_ELEM + status
    localparam int IDX_W   = $clog2(N_BYTES);

    localparam logic [DATA_W-1:0] HEADER = 8'hA5;

    // Status byte layout: {all_match, 3'b000, mismatch[3:0]}
    localparam int STAT_MATCH_BIT = 7;
    localparam int STAT_MASK_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SEND    = 2'd2,
        FINISH  = 2'd3
    } state_t;

    // Element 0 is c11, element 3 is c22.
    typedef logic [N_ELEM-1:0][DATA_W-1:0] elem_set_t;

    typedef struct packed {
        elem_set_t pe;
        elem_set_t sa2;
        elem_set_t sa3;
    } snap_t;

    // An element is inconsistent if either array disagrees with the PE result.
    function automatic logic [N_ELEM-1:0] cross_check(
        input elem_set_t pe,
        input elem_set_t sa2,
        input elem_set_t sa3
    );
        logic [N_ELEM-1:0] m;
        for (int i = 0; i < N_ELEM; i++) begin
            m[i] = (pe[i] != sa2[i]) | (pe[i] != sa3[i]);
        end
        return m;
    endfunction

    function automatic logic [DATA_W-1:0] status_byte(
        input logic              all_match,
        input logic [N_ELEM-1:0] mask
    );
        logic [DATA_W-1:0] s;
        s = '0;
        s[STAT_MATCH_BIT]               = all_match;
        s[STAT_MASK_LSB +: N_ELEM]      = mask;
        return s;
    endfunction

endpackage

// File: rtl/byte_stream_tx.sv
// Registered valid/ready byte transmitter. Walks a fixed-length frame one
// byte per accepted handshake; data and valid only change on a handshake
// or on start, so they stay put while the sink stalls.
module byte_stream_tx
    import conv_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [N_BYTES-1:0][DATA_W-1:0]  frame,
    input  logic                            out_ready,
    output logic [DATA_W-1:0]               out_data,
    output logic                            out_valid,
    output logic                            last_accept
);

    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic             accept;

    assign accept      = out_valid & out_ready;
    assign idx_nxt     = idx + 1'b1;
    assign last_accept = accept && (idx == IDX_W'(N_BYTES - 1));

    // Output register and byte index: load byte 0 on start, advance on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            idx       <= '0;
        end else if (start) begin
            out_valid <= 1'b1;
            out_data  <= frame[0];
            idx       <= '0;
        end else if (last_accept) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            idx       <= '0;
        end else if (accept) begin
            out_data  <= frame[idx_nxt];
            idx       <= idx_nxt;
        end
    end

endmodule

// File: rtl/result_streamer.sv
// Snapshots the PE / SA2x2 / SA3x3 result sets on the rising edge of
// conv_done, cross-checks them and streams a 14-byte frame
// (header, 12 results, status) over a valid/ready byte interface.
module result_streamer
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              conv_done,
    input  logic [DATA_W-1:0] pe_c11,
    input  logic [DATA_W-1:0] pe_c12,
    input  logic [DATA_W-1:0] pe_c21,
    input  logic [DATA_W-1:0] pe_c22,
    input  logic [DATA_W-1:0] sa2_c11,
    input  logic [DATA_W-1:0] sa2_c12,
    input  logic [DATA_W-1:0] sa2_c21,
    input  logic [DATA_W-1:0] sa2_c22,
    input  logic [DATA_W-1:0] sa3_c11,
    input  logic [DATA_W-1:0] sa3_c12,
    input  logic [DATA_W-1:0] sa3_c21,
    input  logic [DATA_W-1:0] sa3_c22,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              all_match,
    output logic [N_ELEM-1:0] mismatch
);

    state_t                         state;
    state_t                         state_nxt;
    logic                           done_q;
    logic                           trig;
    logic                           last_accept;
    snap_t                          snap;
    elem_set_t                      pe_in;
    elem_set_t                      sa2_in;
    elem_set_t                      sa3_in;
    logic [N_ELEM-1:0]              mask;
    logic [N_BYTES-1:0][DATA_W-1:0] frame;

    assign pe_in  = {pe_c22,  pe_c21,  pe_c12,  pe_c11};
    assign sa2_in = {sa2_c22, sa2_c21, sa2_c12, sa2_c11};
    assign sa3_in = {sa3_c22, sa3_c21, sa3_c12, sa3_c11};

    assign trig = conv_done & ~done_q;
    assign mask = cross_check(pe_in, sa2_in, sa3_in);

    assign busy       = (state == CAPTURE) || (state == SEND);
    assign frame_done = (state == FINISH);

    // Delay conv_done by one cycle for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done_q <= 1'b0;
        else        done_q <= conv_done;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; edges outside IDLE are dropped, not queued.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trig) state_nxt = CAPTURE;
            CAPTURE: state_nxt = SEND;
            SEND:    if (last_accept) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Snapshot inputs and update the sticky cross-check flags in CAPTURE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap      <= '0;
            mismatch  <= '0;
            all_match <= 1'b0;
        end else if (state == CAPTURE) begin
            snap.pe   <= pe_in;
            snap.sa2  <= sa2_in;
            snap.sa3  <= sa3_in;
            mismatch  <= mask;
            all_match <= (mask == '0);
        end
    end

    // Assemble the outgoing frame from the snapshot and flags.
    always_comb begin
        frame    = '0;
        frame[0] = HEADER;
        for (int i = 0; i < N_ELEM; i++) begin
            frame[1 + i]            = snap.pe[i];
            frame[1 + N_ELEM + i]   = snap.sa2[i];
            frame[1 + 2*N_ELEM + i] = snap.sa3[i];
        end
        frame[N_BYTES-1] = status_byte(all_match, mismatch);
    end

    byte_stream_tx u_tx (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (state == CAPTURE),
        .frame       (frame),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .last_accept (last_accept)
    );

endmodule

// File: tb/tb_result_streamer.sv
// Directed + randomized bench for result_streamer with a queue-based frame model.
module tb_result_streamer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       conv_done = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] pe_v  [4];
    logic [7:0] sa2_v [4];
    logic [7:0] sa3_v [4];
    logic [7:0] out_data;
    logic       out_valid, busy, frame_done, all_match;
    logic [3:0] mismatch;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] exp_q [$];
    logic [3:0] exp_mask;
    logic       exp_all;

    always #5 clk = ~clk;

    result_streamer dut (
        .clk(clk), .rst_n(rst_n), .conv_done(conv_done),
        .pe_c11(pe_v[0]),   .pe_c12(pe_v[1]),   .pe_c21(pe_v[2]),   .pe_c22(pe_v[3]),
        .sa2_c11(sa2_v[0]), .sa2_c12(sa2_v[1]), .sa2_c21(sa2_v[2]), .sa2_c22(sa2_v[3]),
        .sa3_c11(sa3_v[0]), .sa3_c12(sa3_v[1]), .sa3_c21(sa3_v[2]), .sa3_c22(sa3_v[3]),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .frame_done(frame_done), .all_match(all_match), .mismatch(mismatch)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame: header, PE, SA2, SA3 (c11..c22), then status.
    task automatic build_model();
        logic [3:0] m;
        exp_q = {};
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 4; i++) exp_q.push_back(pe_v[i]);
        for (int i = 0; i < 4; i++) exp_q.push_back(sa2_v[i]);
        for (int i = 0; i < 4; i++) exp_q.push_back(sa3_v[i]);
        for (int i = 0; i < 4; i++) m[i] = (pe_v[i] != sa2_v[i]) || (pe_v[i] != sa3_v[i]);
        exp_mask = m;
        exp_all  = (m == 4'b0000);
        exp_q.push_back({exp_all, 3'b000, m});
    endtask

    task automatic set_std();
        for (int i = 0; i < 4; i++) begin
            pe_v[i]  = 8'(30 + 5*i + ((i >= 2) ? 10 : 0));
            sa2_v[i] = pe_v[i];
            sa3_v[i] = pe_v[i];
        end
    endtask

    task automatic rand_inputs(input int mm_pct);
        for (int i = 0; i < 4; i++) begin
            pe_v[i]  = 8'($urandom_range(0, 255));
            sa2_v[i] = pe_v[i];
            sa3_v[i] = pe_v[i];
            if ($urandom_range(0, 99) < mm_pct) sa2_v[i] = pe_v[i] ^ 8'($urandom_range(1, 255));
            if ($urandom_range(0, 99) < mm_pct) sa3_v[i] = pe_v[i] ^ 8'($urandom_range(1, 255));
        end
    endtask

    // rmode: 0 ready=1, 1 ready pattern 1,0,0, 2 random ready.
    // chg scrambles inputs right after capture; glitch adds a second edge mid-frame.
    task automatic do_frame(input int rmode, input bit chg, input bit glitch);
        int         k;
        int         cyc;
        bit         stalled;
        logic [7:0] prev;
        build_model();
        conv_done = 1'b1;
        tick();
        check("busy_capture", busy, 1);
        check("valid_capture", out_valid, 0);
        tick();
        if (chg) rand_inputs(50);
        check("mismatch_flags", mismatch, exp_mask);
        check("all_match_flag", all_match, exp_all);
        check("first_valid_latency", out_valid, 1);
        k = 0; cyc = 2; stalled = 0; prev = '0;
        while (k < 14 && cyc < 200) begin
            if (glitch && cyc == 6) conv_done = 1'b0;
            if (glitch && cyc == 7) conv_done = 1'b1;
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((cyc - 2) % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            check("valid_hold", out_valid, 1);
            check("busy_send", busy, 1);
            check($sformatf("byte%0d", k), out_data, exp_q[k]);
            if (stalled) check("stall_stable", out_data, prev);
            prev    = out_data;
            stalled = !out_ready;
            if (out_ready) k++;
            tick();
            cyc++;
        end
        check("frame_len", k, 14);
        check("frame_done_high", frame_done, 1);
        check("busy_finish", busy, 0);
        check("valid_finish", out_valid, 0);
        if (rmode == 0) check("frame_done_latency", cyc, 16);
        out_ready = 1'b0;
        tick();
        check("frame_done_pulse", frame_done, 0);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        for (int i = 0; i < 4; i++) begin
            pe_v[i] = '0; sa2_v[i] = '0; sa3_v[i] = '0;
        end
        tick(); tick();
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_all_match", all_match, 0);
        check("rst_mismatch", mismatch, 0);
        rst_n = 1'b1;
        tick();

        // Standard data, all sets agree.
        set_std();
        do_frame(0, 0, 0);
        conv_done = 1'b0;
        tick(); tick(); tick();
        check("sticky_all_match", all_match, 1);
        check("std_status_byte", exp_q[13], 8'h80);

        // Single disagreement on sa3 c21.
        set_std();
        sa3_v[2] = 8'd51;
        do_frame(0, 0, 0);
        check("t2_mismatch_const", mismatch, 4'b0100);
        check("t2_all_match_const", all_match, 0);
        conv_done = 1'b0;
        tick();

        // Backpressure 1,0,0 pattern.
        rand_inputs(30);
        do_frame(1, 0, 0);
        conv_done = 1'b0;
        tick();

        // Held-high done with an extra edge mid-frame: only one frame.
        rand_inputs(30);
        do_frame(0, 0, 1);
        for (int i = 0; i < 30; i++) begin
            check("held_no_busy", busy, 0);
            check("held_no_valid", out_valid, 0);
            tick();
        end
        conv_done = 1'b0;
        tick();

        // Reset while byte 6 is on the bus.
        rand_inputs(40);
        build_model();
        conv_done = 1'b1;
        tick(); tick();
        out_ready = 1'b1;
        k = 0;
        while (k < 6) begin
            tick();
            k++;
        end
        check("pre_reset_byte6", out_data, exp_q[6]);
        rst_n = 1'b0;
        conv_done = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_all_match", all_match, 0);
        check("arst_mismatch", mismatch, 0);
        check("arst_frame_done", frame_done, 0);
        out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        rand_inputs(40);
        do_frame(2, 0, 0);
        conv_done = 1'b0;
        tick();

        // Inputs scrambled right after capture.
        rand_inputs(30);
        do_frame(0, 1, 0);
        conv_done = 1'b0;
        tick();

        // conv_done already high when reset releases: first clock triggers.
        rand_inputs(30);
        rst_n = 1'b0;
        conv_done = 1'b1;
        tick();
        rst_n = 1'b1;
        do_frame(0, 0, 0);
        conv_done = 1'b0;
        tick();

        // Randomized frames with random backpressure and idle gaps.
        for (int f = 0; f < 6; f++) begin
            rand_inputs(25);
            do_frame(2, 1'($urandom_range(0, 1)), 0);
            conv_done = 1'b0;
            for (int g = 0; g < int'($urandom_range(1, 3)); g++) tick();
            check("sticky_mismatch", mismatch, exp_mask);
            check("sticky_all", all_match, exp_all);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
